// File: rtl/uart_rx_pkg.sv
// Shared UART definitions: receiver state encodings, frame width and default line settings.
// Also used by the transmit side so both ends agree on framing.
package uart_rx_pkg;

    localparam int unsigned DATA_BITS          = 8;
    localparam int unsigned DEFAULT_CLK_FREQ   = 50_000_000;
    localparam int unsigned DEFAULT_BAUD       = 9600;
    localparam int unsigned DEFAULT_OVERSAMPLE = 16;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4,
        ST_BREAK  = 3'd5
    } rx_state_e;

    // Even parity: the parity bit makes the total count of ones even.
    function automatic logic even_parity(input logic [DATA_BITS-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversampling tick generator: counts 0..DIV-1 and emits a one-cycle tick after each wrap.
// clr_i holds the counter at zero so a frame always starts on a fresh tick phase.
module uart_baud_tick #(
    parameter int unsigned DIV = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    output logic tick_o
);

    localparam int unsigned CW = $clog2(DIV);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          tick_q, tick_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    always_comb begin
        cnt_d  = cnt_q;
        tick_d = 1'b0;
        if (clr_i) begin
            cnt_d = '0;
        end else if (cnt_q == CW'(DIV - 1)) begin
            cnt_d  = '0;
            tick_d = 1'b1;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    assign tick_o = tick_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with oversampled mid-bit sampling and a held-valid / read-ack output.
// Define UART_RX_PARITY_EN to add an even-parity bit and the parity_err output.
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int unsigned CLK_FREQ   = DEFAULT_CLK_FREQ,
    parameter int unsigned BAUD       = DEFAULT_BAUD,
    parameter int unsigned OVERSAMPLE = DEFAULT_OVERSAMPLE
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    input  logic                 read_en,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 frame_err,
`ifdef UART_RX_PARITY_EN
    output logic                 parity_err,
`endif
    output logic                 overrun
);

    localparam int unsigned TICK_DIV = CLK_FREQ / (BAUD * OVERSAMPLE);
    localparam int unsigned MID      = OVERSAMPLE / 2;
    localparam int unsigned TCW      = $clog2(OVERSAMPLE);
    localparam int unsigned BCW      = $clog2(DATA_BITS);

    logic [1:0]           sync_q;
    logic                 rx_s;
    logic                 tick;

    rx_state_e            state_q, state_d;
    logic [TCW-1:0]       tick_cnt_q, tick_cnt_d;
    logic [BCW-1:0]       bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
    logic                 rx_valid_q, rx_valid_d;
    logic                 frame_err_q, frame_err_d;
    logic                 overrun_q, overrun_d;
`ifdef UART_RX_PARITY_EN
    logic                 par_bad_q, par_bad_d;
    logic                 parity_err_q, parity_err_d;
`endif

    assign rx_s = sync_q[1];

    uart_baud_tick #(
        .DIV (TICK_DIV)
    ) u_tick (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (state_q == ST_IDLE),
        .tick_o (tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q       <= 2'b11;
            state_q      <= ST_IDLE;
            tick_cnt_q   <= '0;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad_q    <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            sync_q       <= {sync_q[0], rx};
            state_q      <= state_d;
            tick_cnt_q   <= tick_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            rx_data_q    <= rx_data_d;
            rx_valid_q   <= rx_valid_d;
            frame_err_q  <= frame_err_d;
            overrun_q    <= overrun_d;
`ifdef UART_RX_PARITY_EN
            par_bad_q    <= par_bad_d;
            parity_err_q <= parity_err_d;
`endif
        end
    end

    always_comb begin
        state_d      = state_q;
        tick_cnt_d   = tick_cnt_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        rx_data_d    = rx_data_q;
        rx_valid_d   = rx_valid_q;
        frame_err_d  = 1'b0;
        overrun_d    = overrun_q;
`ifdef UART_RX_PARITY_EN
        par_bad_d    = par_bad_q;
        parity_err_d = 1'b0;
`endif

        // A read clears both flags; a frame landing this same cycle re-arms valid below.
        if (read_en && rx_valid_q) begin
            rx_valid_d = 1'b0;
            overrun_d  = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (!rx_s) begin
                    state_d    = ST_START;
                    tick_cnt_d = '0;
                end
            end

            ST_START: begin
                if (tick) begin
                    if (tick_cnt_q == TCW'(MID - 1)) begin
                        tick_cnt_d = '0;
                        bit_cnt_d  = '0;
                        state_d    = rx_s ? ST_IDLE : ST_DATA;
                    end else begin
                        tick_cnt_d = tick_cnt_q + TCW'(1);
                    end
                end
            end

            ST_DATA: begin
                if (tick) begin
                    if (tick_cnt_q == TCW'(OVERSAMPLE - 1)) begin
                        tick_cnt_d = '0;
                        shift_d    = {rx_s, shift_q[DATA_BITS-1:1]};
                        bit_cnt_d  = bit_cnt_q + BCW'(1);
                        if (bit_cnt_q == BCW'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
                            state_d = ST_PARITY;
`else
                            state_d = ST_STOP;
`endif
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + TCW'(1);
                    end
                end
            end

`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (tick) begin
                    if (tick_cnt_q == TCW'(OVERSAMPLE - 1)) begin
                        tick_cnt_d = '0;
                        par_bad_d  = (rx_s != even_parity(shift_q));
                        state_d    = ST_STOP;
                    end else begin
                        tick_cnt_d = tick_cnt_q + TCW'(1);
                    end
                end
            end
`endif

            // Stop bit sampled mid-bit; leaving here leaves half a bit for the next start edge.
            ST_STOP: begin
                if (tick) begin
                    if (tick_cnt_q == TCW'(OVERSAMPLE - 1)) begin
                        tick_cnt_d = '0;
`ifdef UART_RX_PARITY_EN
                        parity_err_d = par_bad_q;
                        par_bad_d    = 1'b0;
`endif
                        if (rx_s) begin
                            rx_data_d  = shift_q;
                            rx_valid_d = 1'b1;
                            if (rx_valid_q && !read_en) begin
                                overrun_d = 1'b1;
                            end
                            state_d = ST_IDLE;
                        end else begin
                            frame_err_d = 1'b1;
                            state_d     = ST_BREAK;
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + TCW'(1);
                    end
                end
            end

            ST_BREAK: begin
                if (rx_s) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign rx_data    = rx_data_q;
    assign rx_valid   = rx_valid_q;
    assign frame_err  = frame_err_q;
    assign overrun    = overrun_q;
`ifdef UART_RX_PARITY_EN
    assign parity_err = parity_err_q;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Randomised self-checking bench for uart_rx against a byte-level model of the receive interface.
// Frames are produced by a behavioural transmitter at 160 clk per bit.
module tb_uart_rx;

    localparam int unsigned CLK_FREQ   = 1_600_000;
    localparam int unsigned BAUD       = 10_000;
    localparam int unsigned OVERSAMPLE = 16;
    localparam int unsigned BIT_CLK    = CLK_FREQ / BAUD;

    logic       clk     = 1'b0;
    logic       rst     = 1'b1;
    logic       rx      = 1'b1;
    logic       read_en = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       overrun;
`ifdef UART_RX_PARITY_EN
    logic       parity_err;
`endif

    int          n_vec  = 0;
    int          n_miss = 0;
    int          fe_cnt = 0;
    int unsigned cyc    = 0;

    // Byte-level model of the consumer-facing interface
    logic [7:0]  m_data    = 8'h00;
    logic        m_valid   = 1'b0;
    logic        m_overrun = 1'b0;

    uart_rx #(
        .CLK_FREQ   (CLK_FREQ),
        .BAUD       (BAUD),
        .OVERSAMPLE (OVERSAMPLE)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rx         (rx),
        .read_en    (read_en),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .frame_err  (frame_err),
`ifdef UART_RX_PARITY_EN
        .parity_err (parity_err),
`endif
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) if (frame_err) fe_cnt <= fe_cnt + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish (got timeout, expected completion)");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_frame(input logic [7:0] b, input logic stop_ok);
        if (stop_ok) begin
            if (m_valid) m_overrun = 1'b1;
            m_valid = 1'b1;
            m_data  = b;
        end
    endtask

    task automatic model_reset();
        m_data    = 8'h00;
        m_valid   = 1'b0;
        m_overrun = 1'b0;
    endtask

    task automatic check_outputs(input string tag);
        check_eq({tag, "_data"},    32'(rx_data),  32'(m_data));
        check_eq({tag, "_valid"},   32'(rx_valid), 32'(m_valid));
        check_eq({tag, "_overrun"}, 32'(overrun),  32'(m_overrun));
    endtask

    task automatic do_read();
        @(negedge clk) read_en = 1'b1;
        @(negedge clk) read_en = 1'b0;
        if (m_valid) begin
            m_valid   = 1'b0;
            m_overrun = 1'b0;
        end
    endtask

    task automatic drive_bit(input logic v);
        @(negedge clk) rx = v;
        repeat (BIT_CLK - 1) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
`ifdef UART_RX_PARITY_EN
        drive_bit(^b);
`endif
        drive_bit(stop_bit);
    endtask

    task automatic wait_valid(input int bound);
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (rx_valid) break;
        end
    endtask

    logic [7:0]  lb [4] = '{8'h00, 8'hFF, 8'h55, 8'h80};
    int unsigned t0, lat, fe0;
    logic [7:0]  rb;
    logic        stop_ok;

    initial begin
        // Reset state, both during and after reset
        repeat (5) @(negedge clk);
        check_outputs("rst_hold");
        check_eq("rst_hold_fe", 32'(frame_err), 32'd0);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check_outputs("rst_rel");

        // Single frame 0xA5: valid must appear while the stop bit is on the line
        fork
            send_frame(8'hA5, 1'b1);
        join_none
        t0 = cyc;
        wait_valid(2000);
        lat = cyc - t0;
        check_eq("t1_valid", 32'(rx_valid), 32'd1);
        check_eq("t1_latency_in_stop_bit", 32'(lat >= 9 * BIT_CLK && lat <= 10 * BIT_CLK), 32'd1);
        wait fork;
        model_frame(8'hA5, 1'b1);
        check_outputs("t1");
        do_read();
        check_outputs("t1_read");

        // Short low glitch is rejected as a false start
        fe0 = fe_cnt;
        @(negedge clk) rx = 1'b0;
        repeat (40) @(negedge clk);
        rx = 1'b1;
        repeat (400) @(negedge clk);
        check_outputs("t2");
        check_eq("t2_fe", fe_cnt - fe0, 32'd0);

        // Bad stop bit then a held-low line: one frame error, no restart until high
        fe0 = fe_cnt;
        send_frame(8'h3C, 1'b0);
        repeat (2000) @(negedge clk);
        check_eq("t3_fe", fe_cnt - fe0, 32'd1);
        check_outputs("t3");
        rx = 1'b1;
        repeat (50) @(negedge clk);
        send_frame(8'h42, 1'b1);
        repeat (20) @(negedge clk);
        model_frame(8'h42, 1'b1);
        check_outputs("t3_restart");
        check_eq("t3_fe_after", fe_cnt - fe0, 32'd1);
        do_read();

        // Back-to-back frames without a read raise overrun
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        repeat (20) @(negedge clk);
        model_frame(8'h11, 1'b1);
        model_frame(8'h22, 1'b1);
        check_outputs("t4");
        do_read();
        check_outputs("t4_read");

        // Loopback stream through the behavioural transmitter, consumer reads each byte
        fork
            begin
                for (int i = 0; i < 4; i++) send_frame(lb[i], 1'b1);
            end
            begin
                for (int i = 0; i < 4; i++) begin
                    wait_valid(2000);
                    check_eq("t5_valid", 32'(rx_valid), 32'd1);
                    model_frame(lb[i], 1'b1);
                    check_outputs("t5");
                    do_read();
                end
            end
        join
        repeat (20) @(negedge clk);
        check_outputs("t5_end");

        // Random frames, stop-bit errors, idle gaps and optional reads
        for (int k = 0; k < 20; k++) begin
            rb      = 8'($urandom);
            stop_ok = ($urandom_range(0, 5) != 0);
            fe0     = fe_cnt;
            send_frame(rb, stop_ok);
            rx = 1'b1;
            repeat ($urandom_range(20, 300)) @(negedge clk);
            model_frame(rb, stop_ok);
            check_outputs("rnd");
            check_eq("rnd_fe", fe_cnt - fe0, stop_ok ? 32'd0 : 32'd1);
            if ($urandom_range(0, 1) == 1) begin
                do_read();
                check_outputs("rnd_read");
            end
        end

        // Reset mid-frame with a pending, overrun byte: everything clears at once
        send_frame(8'h5A, 1'b1);
        send_frame(8'h6B, 1'b1);
        repeat (20) @(negedge clk);
        model_frame(8'h5A, 1'b1);
        model_frame(8'h6B, 1'b1);
        check_outputs("t6_pre");
        fork
            send_frame(8'h7E, 1'b1);
        join_none
        repeat (600) @(negedge clk);
        rst = 1'b1;
        #1;
        model_reset();
        check_outputs("t6_rst");
        wait fork;
        repeat (10) @(negedge clk);
        rst = 1'b0;
        repeat (300) @(negedge clk);
        check_outputs("t6_after");
        send_frame(8'h42, 1'b1);
        repeat (20) @(negedge clk);
        model_frame(8'h42, 1'b1);
        check_outputs("t6_42");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
